// File: rtl/booth_mult_seq_if.sv
// -----------------------------------------------------------------------------
// booth_mult_seq_if
// Bundles the signals of the sequential Booth multiplier into one interface.
// It covers the ALU-side start/done handshake with its operands and product,
// and the link to the external 32-bit carry-lookahead adder.
//
// Modports
//   slave  : the multiplier itself (booth_mult_seq)
//   master : the surrounding ALU plus the adder (drives start/operands/adder_sum)
//
// Signals
//   start      ALU -> mult   request, sampled only while ready=1
//   mcand      ALU -> mult   signed multiplicand
//   mplier     ALU -> mult   signed multiplier
//   ready      mult -> ALU   idle, can accept start
//   done       mult -> ALU   one-cycle pulse, product valid
//   prod_hi    mult -> ALU   product[63:32]
//   prod_lo    mult -> ALU   product[31:0]
//   ovf        mult -> ALU   product does not fit in signed 32 bits
//   adder_a    mult -> adder partial-product high word
//   adder_b    mult -> adder mcand, ~mcand or 0
//   adder_cin  mult -> adder 1 only for subtract
//   adder_sum  adder -> mult sum
// -----------------------------------------------------------------------------
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic             ovf;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_sum;

    modport slave (
        input  start, mcand, mplier, adder_sum,
        output ready, done, prod_hi, prod_lo, ovf, adder_a, adder_b, adder_cin
    );

    modport master (
        output start, mcand, mplier, adder_sum,
        input  ready, done, prod_hi, prod_lo, ovf, adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Sequential radix-2 Booth signed multiplier, 32x32 -> 64. Each CALC cycle
// performs one add/subtract through the external carry-lookahead adder and one
// 65-bit arithmetic right shift of {hi, lo, q_m1}. A product takes 32 CALC
// cycles. It is followed by a single DONE cycle that pulses done.
//
// Ports
//   clk   rising-edge clock
//   clrn  asynchronous, active-high reset (clears all state)
//   bus   booth_mult_seq_if.slave: start/ready/done handshake, operands,
//         product, ovf, and the adder link (adder_a/b/cin out, adder_sum in)
//
// Configuration
//   MULT_OVF_DETECT_EN  when defined, ovf is registered on the CALC->DONE
//                       transition as (prod_hi != {32{prod_lo[31]}}). It is
//                       cleared on an accepted start. When undefined, ovf is
//                       tied to 0.
// -----------------------------------------------------------------------------
module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic           clk,
    input logic           clrn,
    booth_mult_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi, lo;
    logic             q_m1;
    logic [CNT_W-1:0] counter;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] b_sel;
    logic             cin_sel;
    logic             v, s;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    assign accept    = (state == IDLE) && bus.start;
    assign last_iter = (counter == CNT_W'(WIDTH - 1));

    // Next-state logic and the adder operand mux.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        b_sel     = '0;
        cin_sel   = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = CALC;
            CALC: begin
                case ({lo[0], q_m1})
                    2'b01:   b_sel = mcand_q;
                    2'b10: begin
                        b_sel   = ~mcand_q;   // hi - mcand as hi + ~mcand + 1
                        cin_sel = 1'b1;
                    end
                    default: b_sel = '0;
                endcase
                if (last_iter) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The adder result can overflow 32 bits. For example, hi - 0x80000000
    // overflows. Recover the true 33rd (sign) bit from the signed-overflow
    // flag so that the arithmetic shift brings in the correct sign.
    assign v      = (hi[WIDTH-1] == b_sel[WIDTH-1]) &&
                    (bus.adder_sum[WIDTH-1] != hi[WIDTH-1]);
    assign s      = bus.adder_sum[WIDTH-1] ^ v;
    assign hi_nxt = {s, bus.adder_sum[WIDTH-1:1]};
    assign lo_nxt = {bus.adder_sum[0], lo[WIDTH-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state   <= IDLE;
            mcand_q <= '0;
            hi      <= '0;
            lo      <= '0;
            q_m1    <= 1'b0;
            counter <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand_q <= bus.mcand;
                hi      <= '0;
                lo      <= bus.mplier;
                q_m1    <= 1'b0;
                counter <= '0;
            end else if (state == CALC) begin
                hi      <= hi_nxt;
                lo      <= lo_nxt;
                q_m1    <= lo[0];
                counter <= counter + 1'b1;
            end
        end
    end

`ifdef MULT_OVF_DETECT_EN
    logic ovf_q;

    // Evaluated on the final shifted value, i.e. the one being written this edge.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if ((state == CALC) && last_iter) begin
            ovf_q <= (hi_nxt != {WIDTH{lo_nxt[WIDTH-1]}});
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.ready     = (state == IDLE);
    assign bus.done      = (state == DONE);
    assign bus.prod_hi   = hi;
    assign bus.prod_lo   = lo;
    assign bus.adder_a   = hi;
    assign bus.adder_b   = b_sel;
    assign bus.adder_cin = cin_sel;
endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
// Directed-vector bench for booth_mult_seq. It models the external 32-bit
// adder as a plain sum. All inputs are driven on the falling edge, and all
// outputs are sampled on the falling edge. Expected ovf follows
// MULT_OVF_DETECT_EN.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;
    logic clk;
    logic clrn;

    booth_mult_seq_if #(.WIDTH(32)) bus ();

    booth_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    // Stand-in for the team carry-lookahead adder.
    assign bus.adder_sum = bus.adder_a + bus.adder_b + {31'd0, bus.adder_cin};

`ifdef MULT_OVF_DETECT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Starts a product at the current falling edge and checks latency, product
    // and ovf. It then checks the cycle after done. On return, the bench sits
    // on the first falling edge with ready=1 again.
    // inject_at > 1 pulses a stray start with different operands mid-CALC.
    task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                            input int inject_at, input logic [63:0] exp_prod, input logic exp_ovf);
        int   cycles;
        logic seen;
        check({name, " ready_before"}, {63'd0, bus.ready}, 64'd1);
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                bus.start  = 1'b0;
                bus.mcand  = 32'hDEAD_BEEF;   // operands may change after acceptance
                bus.mplier = 32'h0BAD_F00D;
            end
            if (inject_at > 1 && cycles == inject_at) begin
                bus.start  = 1'b1;
                bus.mcand  = 32'h1111_1111;
                bus.mplier = 32'h2222_2222;
            end else if (inject_at > 1 && cycles == inject_at + 1) begin
                bus.start = 1'b0;
            end
            seen = bus.done;
        end
        check({name, " latency"}, 64'(cycles), 64'd33);
        check({name, " prod"}, {bus.prod_hi, bus.prod_lo}, exp_prod);
        check({name, " ovf"}, {63'd0, bus.ovf}, {63'd0, exp_ovf & OVF_ON});
        @(negedge clk);
        check({name, " done_pulse_1cyc"}, {63'd0, bus.done}, 64'd0);
        check({name, " ready_after"}, {63'd0, bus.ready}, 64'd1);
        check({name, " prod_held"}, {bus.prod_hi, bus.prod_lo}, exp_prod);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cnt;
        bus.start  = 1'b0;
        bus.mcand  = '0;
        bus.mplier = '0;
        clrn       = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst ready", {63'd0, bus.ready}, 64'd1);
        check("rst done", {63'd0, bus.done}, 64'd0);
        check("rst prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
        check("rst ovf", {63'd0, bus.ovf}, 64'd0);
        check("rst adder_b", {32'd0, bus.adder_b}, 64'd0);
        check("rst adder_cin", {63'd0, bus.adder_cin}, 64'd0);
        clrn = 1'b0;
        @(negedge clk);

        run_mult("3x5", 32'd3, 32'd5, 0, 64'h0000_0000_0000_000F, 1'b0);
        run_mult("m7x6", 32'hFFFF_FFF9, 32'd6, 0, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        run_mult("min_sq", 32'h8000_0000, 32'h8000_0000, 0, 64'h4000_0000_0000_0000, 1'b1);
        run_mult("max_x_m1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 10, 64'hFFFF_FFFF_8000_0001, 1'b0);

        // The stray start must not produce a second done.
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("max_x_m1 single_done", 64'(done_cnt), 64'd0);

        // Reset in the middle of CALC
        bus.start  = 1'b1;
        bus.mcand  = 32'd5;
        bus.mplier = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        clrn = 1'b1;
        #1;
        check("midrst ready", {63'd0, bus.ready}, 64'd1);
        check("midrst done", {63'd0, bus.done}, 64'd0);
        check("midrst prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
        check("midrst ovf", {63'd0, bus.ovf}, 64'd0);
        @(negedge clk);
        clrn = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("midrst no_done", 64'(done_cnt), 64'd0);
        run_mult("2x2", 32'd2, 32'd2, 0, 64'd4, 1'b0);

        // Back-to-back products, each started on the first ready cycle
        run_mult("b2b_pos", 32'h1234_5678, 32'h0000_0010, 0, 64'h0000_0001_2345_6780, 1'b1);
        run_mult("b2b_m1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'h0000_0000_0000_0001, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
